// File: rtl/p2s_pkg.sv
// Shared types for the OFDM parallel-to-serial streamer: FSM states and the complex sample.
// The sample struct is fixed at P2S_WIDTH; the top checks that its WIDTH parameter matches.
package p2s_pkg;

    localparam int P2S_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        BODY = 2'd2
    } p2s_state_t;

    typedef struct packed {
        logic signed [P2S_WIDTH-1:0] i;
        logic signed [P2S_WIDTH-1:0] q;
    } p2s_sample_t;

endpackage

// File: rtl/p2s_symbol_buf.sv
// Active/pending symbol register bank for the OFDM P2S streamer.
// Provides load-into-active, load-into-pending, pending->active transfer and an indexed read of active.
module p2s_symbol_buf
    import p2s_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_act,
    input  logic                          load_pend,
    input  logic                          xfer,
    input  logic [DEPTH-1:0][WIDTH-1:0]   in_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]   in_q,
    input  logic [$clog2(DEPTH)-1:0]      rd_idx,
    output p2s_sample_t                   rd,
    output logic                          pending_full
);

    p2s_sample_t act  [DEPTH];
    p2s_sample_t pend [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                act[k]  <= '0;
                pend[k] <= '0;
            end
            pending_full <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                // load_act and xfer are mutually exclusive: a transfer blocks acceptance
                if (load_act) begin
                    act[k].i <= in_i[k];
                    act[k].q <= in_q[k];
                end else if (xfer) begin
                    act[k] <= pend[k];
                end
                if (load_pend) begin
                    pend[k].i <= in_i[k];
                    pend[k].q <= in_q[k];
                end
            end
            if (load_pend) begin
                pending_full <= 1'b1;
            end else if (xfer) begin
                pending_full <= 1'b0;
            end
        end
    end

    assign rd = act[rd_idx];

endmodule

// File: rtl/ofdm_p2s_stream.sv
// OFDM symbol parallel-to-serial streamer with double buffering for back-to-back symbols.
// Define P2S_CP_EN to prepend a CP_LEN-sample cyclic prefix to each symbol.
//
// state | meaning
// IDLE  | no symbol held, out_valid low
// CP    | emitting cyclic prefix, indices DEPTH-CP_LEN .. DEPTH-1
// BODY  | emitting symbol body, indices 0 .. DEPTH-1
module ofdm_p2s_stream
    import p2s_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 64,
    parameter int CP_LEN = 16
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DEPTH-1:0][WIDTH-1:0]   in_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]   in_q,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [WIDTH-1:0]       out_i,
    output logic signed [WIDTH-1:0]       out_q,
    output logic                          out_first,
    output logic                          out_last
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

`ifdef P2S_CP_EN
    localparam logic [IDX_W-1:0] START_IDX = IDX_W'(DEPTH - CP_LEN);
    localparam p2s_state_t       START_ST  = CP;
`else
    localparam logic [IDX_W-1:0] START_IDX = '0;
    localparam p2s_state_t       START_ST  = BODY;
`endif

    if (WIDTH != P2S_WIDTH) begin : g_bad_width
        $error("ofdm_p2s_stream: WIDTH must equal p2s_pkg::P2S_WIDTH");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ofdm_p2s_stream: DEPTH must be a power of two >= 4");
    end
    if (CP_LEN < 1 || CP_LEN > DEPTH) begin : g_bad_cp
        $error("ofdm_p2s_stream: CP_LEN must be in 1..DEPTH");
    end

    p2s_state_t       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             pending_full;
    logic             accept, beat, last_beat;
    logic             load_act, load_pend, xfer;
    p2s_sample_t      rd;

    assign in_ready  = !pending_full && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q != IDLE) && !rst;
    assign beat      = out_valid && out_ready;
    assign last_beat = beat && (state_q == BODY) && (cnt_q == LAST_IDX);

    // pending_full blocks acceptance, so a transfer and a direct load never coincide
    assign load_act  = accept && ((state_q == IDLE) || last_beat);
    assign load_pend = accept && !load_act;
    assign xfer      = last_beat && pending_full;

    p2s_symbol_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .load_act     (load_act),
        .load_pend    (load_pend),
        .xfer         (xfer),
        .in_i         (in_i),
        .in_q         (in_q),
        .rd_idx       (cnt_q),
        .rd           (rd),
        .pending_full (pending_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START_ST;
                    cnt_d   = START_IDX;
                end
            end
`ifdef P2S_CP_EN
            CP: begin
                if (beat) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = BODY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`endif
            BODY: begin
                if (beat) begin
                    if (cnt_q == LAST_IDX) begin
                        if (pending_full || accept) begin
                            state_d = START_ST;
                            cnt_d   = START_IDX;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign out_i    = out_valid ? rd.i : '0;
    assign out_q    = out_valid ? rd.q : '0;
    assign out_last = out_valid && (state_q == BODY) && (cnt_q == LAST_IDX);
`ifdef P2S_CP_EN
    assign out_first = out_valid && (state_q == CP) && (cnt_q == START_IDX);
`else
    assign out_first = out_valid && (state_q == BODY) && (cnt_q == '0);
`endif

endmodule

// File: tb/tb_ofdm_p2s_stream.sv
// Bench for ofdm_p2s_stream: queue-based beat model checked every cycle, plus literal expectations.
module tb_ofdm_p2s_stream;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int CP_LEN = 2;
`ifdef P2S_CP_EN
    localparam bit CP_ON = 1'b1;
`else
    localparam bit CP_ON = 1'b0;
`endif
    localparam int BEATS = CP_ON ? DEPTH + CP_LEN : DEPTH;

    typedef logic [DEPTH-1:0][WIDTH-1:0] sym_t;
    typedef struct {
        int i;
        int q;
        bit first;
        bit last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, out_first, out_last;
    sym_t in_i = '0;
    sym_t in_q = '0;
    logic signed [WIDTH-1:0] out_i, out_q;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int outstanding = 0;
    int stall_cnt = 0;
    beat_t exp_q[$];
    int log_i[$];
    int log_q[$];
    bit log_f[$];
    bit log_l[$];
    int log_c[$];

    sym_t sa_i, sa_q, sb_i, sb_q, sx_i, sx_q;
    int seq_a[$];

    ofdm_p2s_stream #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .CP_LEN (CP_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_i      (in_i),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A symbol turns into its beat list: optional prefix (tail samples) then the whole body.
    task automatic push_symbol(input sym_t si, input sym_t sq);
        beat_t b;
        if (CP_ON) begin
            for (int k = DEPTH - CP_LEN; k < DEPTH; k++) begin
                b.i = int'($signed(si[k]));
                b.q = int'($signed(sq[k]));
                b.first = (k == DEPTH - CP_LEN);
                b.last = 1'b0;
                exp_q.push_back(b);
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            b.i = int'($signed(si[k]));
            b.q = int'($signed(sq[k]));
            b.first = !CP_ON && (k == 0);
            b.last = (k == DEPTH - 1);
            exp_q.push_back(b);
        end
    endtask

    always @(negedge clk) begin : cmp
        beat_t b;
        if (rst) begin
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_in_ready", longint'(in_ready), 0);
            chk("rst_out_i", longint'(out_i), 0);
            chk("rst_out_first", longint'(out_first), 0);
            chk("rst_out_last", longint'(out_last), 0);
            exp_q.delete();
            outstanding = 0;
        end else begin
            chk("in_ready", longint'(in_ready), longint'(outstanding < 2));
            chk("out_valid", longint'(out_valid), longint'(exp_q.size() > 0));
            if (out_valid && exp_q.size() > 0) begin
                b = exp_q[0];
                chk("out_i", longint'(out_i), b.i);
                chk("out_q", longint'(out_q), b.q);
                chk("out_first", longint'(out_first), longint'(b.first));
                chk("out_last", longint'(out_last), longint'(b.last));
            end
            if (out_valid && !out_ready) stall_cnt++;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                log_i.push_back(int'(out_i));
                log_q.push_back(int'(out_q));
                log_f.push_back(out_first);
                log_l.push_back(out_last);
                log_c.push_back(cyc);
                if (b.last) outstanding--;
            end
            if (in_valid && in_ready) begin
                push_symbol(in_i, in_q);
                outstanding++;
            end
        end
    end

    task automatic clear_log();
        log_i.delete();
        log_q.delete();
        log_f.delete();
        log_l.delete();
        log_c.delete();
        stall_cnt = 0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input sym_t si, input sym_t sq);
        int n = 0;
        in_i = si;
        in_q = sq;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, longint'(exp_q.size() == 0 && !out_valid), 1);
    endtask

    task automatic check_seq(input string name, input int exp[$]);
        chk(name, log_i.size(), exp.size());
        foreach (exp[k]) begin
            if (k < log_i.size()) chk(name, log_i[k], exp[k]);
        end
    endtask

    initial begin
        int n;
        for (int k = 0; k < DEPTH; k++) begin
            sa_i[k] = WIDTH'(10 * (k + 1));
            sa_q[k] = WIDTH'(-(k + 1));
            sb_i[k] = WIDTH'(110 + 10 * k);
            sb_q[k] = WIDTH'(100 + k);
            sx_i[k] = WIDTH'(k);
            sx_q[k] = WIDTH'(-k);
        end
        sx_i[0] = 16'h8000;
        sx_i[DEPTH-1] = 16'h7FFF;
        sx_q[0] = 16'h7FFF;
        sx_q[DEPTH-1] = 16'h8000;
        if (CP_ON) seq_a = '{70, 80, 10, 20, 30, 40, 50, 60, 70, 80};
        else       seq_a = '{10, 20, 30, 40, 50, 60, 70, 80};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_init", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        // single symbol, free-running sink
        clear_log();
        send(sa_i, sa_q);
        drain("t1_drain");
        check_seq("t1_seq", seq_a);
        if (log_f.size() == BEATS) begin
            chk("t1_first_flag", longint'(log_f[0]), 1);
            chk("t1_last_flag", longint'(log_l[BEATS-1]), 1);
            chk("t1_q_last", log_q[BEATS-1], -8);
        end

        // back-to-back: B lands in pending while A streams
        clear_log();
        send(sa_i, sa_q);
        send(sb_i, sb_q);
        @(negedge clk);
        chk("t2_in_ready_pending", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        drain("t2_drain");
        chk("t2_beats", log_i.size(), 2 * BEATS);
        if (log_i.size() == 2 * BEATS) begin
            chk("t2_a_last", log_i[BEATS-1], 80);
            chk("t2_b_first", log_i[BEATS], CP_ON ? 170 : 110);
            chk("t2_b_first_flag", longint'(log_f[BEATS]), 1);
            chk("t2_no_bubble", log_c[2*BEATS-1] - log_c[0], 2 * BEATS - 1);
        end

        // stall at sample 30
        clear_log();
        send(sa_i, sa_q);
        n = 0;
        while (!(out_valid && out_i == 30) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_found_30", longint'(out_valid && out_i == 30), 1);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        drain("t3_drain");
        chk("t3_stall_cycles", stall_cnt, 3);
        check_seq("t3_seq", seq_a);

        // reset mid-symbol at the 5th beat, with in_valid ignored during reset
        clear_log();
        send(sa_i, sa_q);
        n = 0;
        while (log_i.size() < 4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t4_reached_beat5", log_i.size(), 4);
        rst = 1'b1;
        in_i = sb_i;
        in_q = sb_q;
        in_valid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_in_ready_after_rst", longint'(in_ready), 1);
        chk("t4_idle_after_rst", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        clear_log();
        send(sa_i, sa_q);
        drain("t4_drain");
        check_seq("t4_seq", seq_a);
        if (log_f.size() > 0) chk("t4_first_flag", longint'(log_f[0]), 1);

        // full-scale extremes pass through bit-exact
        clear_log();
        send(sx_i, sx_q);
        drain("t5_drain");
        chk("t5_beats", log_i.size(), BEATS);
        if (log_i.size() == BEATS) begin
            chk("t5_i_min", log_i[CP_ON ? CP_LEN : 0], -32768);
            chk("t5_q_max", log_q[CP_ON ? CP_LEN : 0], 32767);
            chk("t5_i_max", log_i[BEATS-1], 32767);
            chk("t5_q_min", log_q[BEATS-1], -32768);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
